// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execution unit: iterative shift-add multiply and restoring
// divide, one step per cycle, with a pipeline stall and a one-cycle done pulse.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      aluSelect,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN + 1);

  localparam logic [5:0] C_MUL    = 6'b100110;
  localparam logic [5:0] C_MULH   = 6'b100111;
  localparam logic [5:0] C_MULHSU = 6'b101000;
  localparam logic [5:0] C_MULHU  = 6'b101001;
  localparam logic [5:0] C_DIV    = 6'b101010;
  localparam logic [5:0] C_DIVU   = 6'b101011;
  localparam logic [5:0] C_REM    = 6'b101100;
  localparam logic [5:0] C_REMU   = 6'b101101;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [5:0]      op_q, op_d;
  logic            sign_a, sign_a_d, sign_b, sign_b_d;
  logic [XLEN-1:0] opnd, opnd_d;
  logic [XLEN-1:0] acc_hi, acc_hi_d, acc_lo, acc_lo_d;
  logic [XLEN-1:0] result_d;

  // Decode of the incoming instruction (only meaningful in IDLE)
  logic            is_m_in, is_div_in, signed_a_in, signed_b_in;
  logic            neg_a, neg_b, accept, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_val;

  assign is_m_in     = aluSelect inside {C_MUL, C_MULH, C_MULHSU, C_MULHU,
                                         C_DIV, C_DIVU, C_REM, C_REMU};
  assign is_div_in   = aluSelect inside {C_DIV, C_DIVU, C_REM, C_REMU};
  assign signed_a_in = aluSelect inside {C_MUL, C_MULH, C_MULHSU, C_DIV, C_REM};
  assign signed_b_in = aluSelect inside {C_MUL, C_MULH, C_DIV, C_REM};
  assign neg_a       = signed_a_in & opA[XLEN-1];
  assign neg_b       = signed_b_in & opB[XLEN-1];
  assign mag_a       = neg_a ? (~opA) + XLEN'(1) : opA;
  assign mag_b       = neg_b ? (~opB) + XLEN'(1) : opB;
  assign accept      = start & is_m_in & ~flush;
  assign div_zero    = is_div_in & (opB == '0);
  assign div_ovf     = (aluSelect inside {C_DIV, C_REM}) & (opA == MIN_NEG) & (opB == '1);
  assign special     = div_zero | div_ovf;

  always_comb begin
    special_val = '0;
    if (div_zero) begin
      special_val = (aluSelect inside {C_DIV, C_DIVU}) ? '1 : opA;
    end else if (div_ovf) begin
      special_val = (aluSelect == C_DIV) ? MIN_NEG : '0;
    end
  end

  // One iteration of the running operation; shares acc_hi/acc_lo between
  // {product high, multiplier} and {remainder, dividend/quotient}.
  logic            is_div_q;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  assign is_div_q  = op_q inside {C_DIV, C_DIVU, C_REM, C_REMU};
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  always_comb begin
    if (is_div_q) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  // Sign correction applied to the value produced by the final step
  logic [PW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, final_val;

  assign prod     = {step_hi, step_lo};
  assign prod_fix = (sign_a ^ sign_b) ? (~prod) + PW'(1) : prod;
  assign quo_fix  = (sign_a ^ sign_b) ? (~step_lo) + XLEN'(1) : step_lo;
  assign rem_fix  = sign_a ? (~step_hi) + XLEN'(1) : step_hi;

  always_comb begin
    case (op_q)
      C_MUL:                      final_val = prod_fix[XLEN-1:0];
      C_MULH, C_MULHSU, C_MULHU:  final_val = prod_fix[PW-1:XLEN];
      C_DIV, C_DIVU:              final_val = quo_fix;
      default:                    final_val = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    op_d     = op_q;
    sign_a_d = sign_a;
    sign_b_d = sign_b;
    opnd_d   = opnd;
    acc_hi_d = acc_hi;
    acc_lo_d = acc_lo;
    result_d = result;
    case (state)
      IDLE: begin
        if (accept) begin
          op_d     = aluSelect;
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          cnt_d    = CW'(XLEN);
          acc_hi_d = '0;
          opnd_d   = is_div_in ? mag_b : mag_a;
          acc_lo_d = is_div_in ? mag_a : mag_b;
          if (special) begin
            result_d = special_val;
            state_d  = DONE;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_d = final_val;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A redirect abandons whatever is in flight and leaves result untouched
    if (flush) begin
      state_d  = IDLE;
      result_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      op_q   <= op_d;
      sign_a <= sign_a_d;
      sign_b <= sign_b_d;
      opnd   <= opnd_d;
      acc_hi <= acc_hi_d;
      acc_lo <= acc_lo_d;
      result <= result_d;
    end
  end

  // Handshake: stall is high from the accept cycle through the last RUN
  // cycle; done is the single cycle the pipeline captures result.
  assign stall     = ((state == IDLE) & accept) | (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) & ~flush;
  assign state_dbg = state;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle execution controller for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the EX stage.
- Accepts the decoded 6-bit aluSelect code plus two operands, then runs an iterative shift-add multiply or restoring divide over XLEN cycles.
- Holds the pipeline with a stall signal and returns a one-cycle-valid result.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  EX-stage instruction valid this cycle.
aluSelect  input  6  decoded operation code.
opA  input  XLEN  rs1 value.
opB  input  XLEN  rs2 value.
flush  input  1  synchronous abort (branch/jump redirect).
stall  output  1  hold IF/ID/EX pipeline registers.
busy  output  1  sequencer not in IDLE.
done  output  1  result valid, one cycle.
result  output  XLEN  operation result.

Behaviour:
- Codes: MUL=100110, MULH=100111, MULHSU=101000, MULHU=101001, DIV=101010, DIVU=101011, REM=101100, REMU=101101. Any other code is not M-type.
- Reset (async, rst_n=0): state=IDLE; counter, accumulators, result=0; done=0; busy=0. Reset mid-operation discards all progress.
- States: IDLE, RUN, DONE.
- IDLE accept: start=1, M-type code, flush=0 → latch op and signs, store operand magnitudes.
  - Signed: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats only opA as signed. Other ops use raw operands.
  - Load counter=XLEN → RUN.
  - Non-M-type start is ignored (stall=0).
- Special cases, detected at accept, skip RUN and go straight to DONE:
  - Divisor 0: DIV/DIVU result = all ones; REM/REMU result = opA.
  - Signed overflow (opA=0x80000000, opB=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- RUN:
  - Multiply: one shift-add step per cycle into a 2*XLEN product.
  - Divide: one restoring step per cycle (shift remainder, trial-subtract, set quotient bit).
  - Counter decrements each cycle; at counter=1 → DONE on the next edge.
- Transition into DONE:
  - Apply sign correction. Negate the product if signs differ. Quotient sign = signA^signB; remainder sign = signA.
  - Select output: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the selection into result.
- DONE: done=1 for exactly one cycle; result holds until the next DONE or reset. Next edge → IDLE unconditionally.
- A start presented during the DONE cycle is the same EX instruction advancing and is not re-accepted. A new accept needs IDLE.
- Latency:
  - Normal path: accept edge E0, RUN edges E1..E32, done visible the cycle after E32 (32 cycles after accept, 33 cycles of stall including the accept cycle).
  - Special-case path: done visible the cycle after accept (1 stall cycle).
- stall = (IDLE & start & M-type & ~flush) | RUN. stall is 0 in the DONE cycle so the pipeline captures result.
- busy = (state != IDLE).
- flush=1 in any state:
  - Next state IDLE; done suppressed.
  - result keeps its previous value.
  - flush takes priority over accept and over the DONE transition.
- start and opA/opB/aluSelect are ignored while busy. Operands are latched and may change after accept.

Test Plan:
- MUL opA=7, opB=0xFFFFFFFD → stall high 33 cycles, done pulses once, result=0xFFFFFFEB. Back-to-back MULU-free ADD code (011100) with start → no stall, no done.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each done exactly 32 cycles after accept.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Done in the cycle after accept, stall for one cycle only.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Single-cycle path.
- Abort cases:
  - flush asserted at RUN iteration 10 → IDLE next cycle, no done, result unchanged; a following DIVU 9/3 → 3.
  - rst_n pulsed low mid-RUN → all outputs 0 immediately, IDLE after release.
